alu_share_ctrl: RTL and testbench

Sequencer/arbiter that time-shares the single combinational 4-bit ALU between two requesters. Accepts one operation at a time over valid/ready, drives the ALU operand/opcode bus from registers, captures result and flags, and returns them with a valid/ready response tagged with the requester ID. Sits between the two issuing units and the ALU instance. It is the only driver of the ALU inputs.

---
 rtl/alu_share_ctrl.sv | 171 +++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_ctrl
// Purpose  : Time-shares one combinational 4-bit ALU between two requesters.
//            A round-robin arbiter accepts one operation at a time over
//            valid/ready. The accepted operation drives the ALU from
//            registers for one cycle. The result and the sanitised flags
//            are captured and returned on a valid/ready response tagged
//            with the requester ID.
// Option   : define ALU_SHARE_STICKY_FLAGS_EN to build the sticky-flag
//            accumulator. When it is undefined, sticky_flags_o is tied to
//            zero and flags_clr_i is ignored.
// Ports    : clk_i, rst_ni           clock, synchronous active-low reset
//            req_valid_i[1:0]        per-requester request valid
//            req_opcode/op1/op2_i    requester i fields at [4i+3:4i]
//            req_ready_o[1:0]        one-hot grant (IDLE only)
//            alu_opcode/op1/op2_o    registered ALU operand bus
//            alu_dout_i, alu_eflags_i  ALU result and flags {Z,N,V,C}
//            rsp_valid_o, rsp_id_o, rsp_dout_o, rsp_eflags_o, rsp_ready_i
//            flags_clr_i, sticky_flags_o  sticky flag clear / accumulator
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_ctrl (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_valid_i,
  input  logic [7:0] req_opcode_i,
  input  logic [7:0] req_op1_i,
  input  logic [7:0] req_op2_i,
  output logic [1:0] req_ready_o,
  output logic [3:0] alu_opcode_o,
  output logic [3:0] alu_op1_o,
  output logic [3:0] alu_op2_o,
  input  logic [3:0] alu_dout_i,
  input  logic [3:0] alu_eflags_i,
  output logic       rsp_valid_o,
  output logic       rsp_id_o,
  output logic [3:0] rsp_dout_o,
  output logic [3:0] rsp_eflags_o,
  input  logic       rsp_ready_i,
  input  logic       flags_clr_i,
  output logic [3:0] sticky_flags_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q;
  logic       ptr_q;        // requester favoured when both are valid
  logic       id_q;
  logic [3:0] opcode_q;
  logic [3:0] op1_q;
  logic [3:0] op2_q;
  logic [3:0] dout_q;
  logic [3:0] eflags_q;
  logic       rsp_valid_q;

  logic [1:0] w_grant;
  logic       w_sel;
  logic       w_supported;
  logic       w_flags_def;
  logic [3:0] w_san_dout;
  logic [3:0] w_san_flags;

  // Grant is combinational so a requester sees ready in its own valid cycle.
  // Gated by rst_ni so nothing is granted while reset is being applied.
  always_comb begin
    w_grant = 2'b00;
    if (rst_ni && (state_q == IDLE)) begin
      case (req_valid_i)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = ptr_q ? 2'b10 : 2'b01;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign w_sel = w_grant[1];

  // Opcodes 0001..0101 are implemented by the ALU. Only add (0001) and
  // cmp (0011) produce meaningful flags.
  assign w_supported = (opcode_q >= 4'd1) && (opcode_q <= 4'd5);
  assign w_flags_def = (opcode_q == 4'd1) || (opcode_q == 4'd3);
  assign w_san_dout  = w_supported ? alu_dout_i   : 4'b0000;
  assign w_san_flags = w_flags_def ? alu_eflags_i : 4'b0000;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      id_q        <= 1'b0;
      opcode_q    <= 4'b0000;
      op1_q       <= 4'b0000;
      op2_q       <= 4'b0000;
      dout_q      <= 4'b0000;
      eflags_q    <= 4'b0000;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|w_grant) begin
            id_q     <= w_sel;
            opcode_q <= w_sel ? req_opcode_i[7:4] : req_opcode_i[3:0];
            op1_q    <= w_sel ? req_op1_i[7:4]    : req_op1_i[3:0];
            op2_q    <= w_sel ? req_op2_i[7:4]    : req_op2_i[3:0];
            ptr_q    <= ~ptr_q;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          dout_q      <= w_san_dout;
          eflags_q    <= w_san_flags;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = w_grant;
  assign alu_opcode_o = opcode_q;
  assign alu_op1_o    = op1_q;
  assign alu_op2_o    = op2_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = id_q;
  assign rsp_dout_o   = dout_q;
  assign rsp_eflags_o = eflags_q;

`ifdef ALU_SHARE_STICKY_FLAGS_EN
  logic [3:0] sticky_q;
  logic [3:0] sticky_d;

  // A clear in the capture cycle drops the old history but keeps the
  // flags being captured in that same cycle.
  always_comb begin
    sticky_d = sticky_q;
    if (state_q == EXEC) begin
      sticky_d = (flags_clr_i ? 4'b0000 : sticky_q) | w_san_flags;
    end else if (flags_clr_i) begin
      sticky_d = 4'b0000;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sticky_q <= 4'b0000;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_flags_o = sticky_q;
`else
  logic w_unused_flags_clr;
  assign w_unused_flags_clr = flags_clr_i;
  assign sticky_flags_o     = 4'b0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_ctrl
// Purpose  : Self-checking bench for alu_share_ctrl. A behavioural ALU
//            answers the controller. An arbitration checker predicts
//            grants and queues the expected responses. A separate monitor
//            pops and compares every presented response, and also tracks
//            the sticky flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [7:0] req_opcode, req_op1, req_op2;
  logic [1:0] req_ready;
  logic [3:0] alu_opcode, alu_op1, alu_op2, alu_dout, alu_eflags;
  logic       rsp_valid, rsp_id, rsp_ready, flags_clr;
  logic [3:0] rsp_dout, rsp_eflags, sticky_flags;

  always #5 clk = ~clk;

  alu_share_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_opcode_i   (req_opcode),
    .req_op1_i      (req_op1),
    .req_op2_i      (req_op2),
    .req_ready_o    (req_ready),
    .alu_opcode_o   (alu_opcode),
    .alu_op1_o      (alu_op1),
    .alu_op2_o      (alu_op2),
    .alu_dout_i     (alu_dout),
    .alu_eflags_i   (alu_eflags),
    .rsp_valid_o    (rsp_valid),
    .rsp_id_o       (rsp_id),
    .rsp_dout_o     (rsp_dout),
    .rsp_eflags_o   (rsp_eflags),
    .rsp_ready_i    (rsp_ready),
    .flags_clr_i    (flags_clr),
    .sticky_flags_o (sticky_flags)
  );

  // Behavioural ALU: returns {flags{Z,N,V,C}, dout}. Operations without
  // defined flags return nonzero junk flags so forcing to zero is visible.
  function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] d;
    logic       v;
    logic [3:0] junk;
    junk = {a[0], b[0], 1'b1, ~a[3]};
    case (op)
      4'd1: begin
        s = {1'b0, a} + {1'b0, b};
        d = s[3:0];
        v = (a[3] == b[3]) && (d[3] != a[3]);
        return {(d == 4'd0), d[3], v, s[4], d};
      end
      4'd3: begin
        s = {1'b0, a} - {1'b0, b};
        d = s[3:0];
        v = (a[3] != b[3]) && (d[3] != a[3]);
        return {(d == 4'd0), d[3], v, s[4], d};
      end
      4'd2:    begin d = a * b;         return {junk, d}; end
      4'd4:    begin d = a << 1;        return {junk, d}; end
      4'd5:    begin d = a >> 1;        return {junk, d}; end
      default: begin d = a ^ b ^ 4'hA;  return {junk, d}; end
    endcase
  endfunction

  assign {alu_eflags, alu_dout} = alu_model(alu_opcode, alu_op1, alu_op2);

  typedef struct {
    logic       id;
    logic [3:0] dout;
    logic [3:0] flags;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  bit   grant_log[$];
  int   errs = 0, checks = 0, cyc = 0, grants_total = 0;
  bit   ptr_m = 1'b0, idle_m = 1'b1;
  logic       last_id;
  logic [3:0] last_dout, last_flags;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Arbitration checker and scoreboard producer (samples at posedge+3).
  always @(posedge clk) begin
    logic [1:0] g;
    logic [3:0] op, a, b;
    logic [7:0] r;
    exp_t       e;
    #3;
    if (!rst_n) begin
      chk("reset_req_ready", {30'd0, req_ready}, 32'd0);
      ptr_m  = 1'b0;
      idle_m = 1'b1;
      sb.delete();
    end else if (idle_m) begin
      if (req_valid == 2'b11) g = ptr_m ? 2'b10 : 2'b01;
      else                    g = req_valid;
      chk("grant", {30'd0, req_ready}, {30'd0, g});
      if (g != 2'b00) begin
        e.id  = g[1];
        op    = req_opcode[4*e.id +: 4];
        a     = req_op1[4*e.id +: 4];
        b     = req_op2[4*e.id +: 4];
        r     = alu_model(op, a, b);
        e.dout  = (op >= 4'd1 && op <= 4'd5) ? r[3:0] : 4'd0;
        e.flags = (op == 4'd1 || op == 4'd3) ? r[7:4] : 4'd0;
        e.cyc   = cyc + 2;
        sb.push_back(e);
        grant_log.push_back(e.id);
        ptr_m  = ~ptr_m;
        idle_m = 1'b0;
        grants_total++;
      end
    end else begin
      chk("busy_req_ready", {30'd0, req_ready}, 32'd0);
    end
  end

  // Response monitor and sticky-flag model (samples at posedge+4).
  always @(posedge clk) begin
    logic [3:0] sticky_m;
    logic       prev_v, clr_prev, cap;
    exp_t       e;
    #4;
    if (!rst_n) begin
      prev_v   = 1'b0;
      clr_prev = 1'b0;
      sticky_m = 4'd0;
    end else begin
      cap = 1'b0;
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end else begin
          e = sb[0];
          if (!prev_v) begin
            cap = 1'b1;
            chk("latency_cycle", cyc, e.cyc);
          end
          chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
          chk("rsp_dout", {28'd0, rsp_dout}, {28'd0, e.dout});
          chk("rsp_eflags", {28'd0, rsp_eflags}, {28'd0, e.flags});
          if (rsp_ready) begin
            last_id    = e.id;
            last_dout  = e.dout;
            last_flags = e.flags;
            void'(sb.pop_front());
            idle_m = 1'b1;
          end
        end
      end
      if (cap)           sticky_m = (clr_prev ? 4'd0 : sticky_m) | e.flags;
      else if (clr_prev) sticky_m = 4'd0;
`ifdef ALU_SHARE_STICKY_FLAGS_EN
      chk("sticky_flags", {28'd0, sticky_flags}, {28'd0, sticky_m});
`else
      chk("sticky_flags_off", {28'd0, sticky_flags}, 32'd0);
`endif
      prev_v   = rsp_valid;
      clr_prev = flags_clr;
    end
  end

  task automatic set_req(input int i, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    req_opcode[4*i +: 4] = op;
    req_op1[4*i +: 4]    = a;
    req_op2[4*i +: 4]    = b;
  endtask

  // Called at posedge+1; returns at posedge+1 of the EXEC cycle.
  task automatic issue(input logic [1:0] mask);
    int g0;
    bit ok;
    g0 = grants_total;
    ok = 1'b0;
    req_valid = mask;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (grants_total != g0) begin ok = 1'b1; break; end
    end
    req_valid = 2'b00;
    chk("grant_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (idle_m && sb.size() == 0) begin ok = 1'b1; break; end
    end
    chk("drain_timeout", {31'd0, ok}, 32'd1);
  endtask

  logic [3:0] exp_sticky_hist, exp_sticky_clr;

  initial begin
    int g0;
    bit ok;
`ifdef ALU_SHARE_STICKY_FLAGS_EN
    exp_sticky_hist = 4'b1001;
    exp_sticky_clr  = 4'b1000;
`else
    exp_sticky_hist = 4'b0000;
    exp_sticky_clr  = 4'b0000;
`endif
    rst_n = 1'b0; req_valid = 2'b00; req_opcode = 8'd0; req_op1 = 8'd0; req_op2 = 8'd0;
    rsp_ready = 1'b1; flags_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #2;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_rsp_dout", {28'd0, rsp_dout}, 32'd0);
    chk("rst_rsp_eflags", {28'd0, rsp_eflags}, 32'd0);
    chk("rst_alu_bus", {20'd0, alu_opcode, alu_op1, alu_op2}, 32'd0);
    chk("rst_sticky", {28'd0, sticky_flags}, 32'd0);
    @(posedge clk); #1;

    // Basic add on requester 0
    set_req(0, 4'd1, 4'd3, 4'd4); issue(2'b01); wait_idle();
    chk("add_id", {31'd0, last_id}, 32'd0);
    chk("add_dout", {28'd0, last_dout}, 32'h7);
    chk("add_flags", {28'd0, last_flags}, 32'h0);

    // Carry add on requester 1
    set_req(1, 4'd1, 4'd7, 4'd9); issue(2'b10); wait_idle();
    chk("carry_id", {31'd0, last_id}, 32'd1);
    chk("carry_dout", {28'd0, last_dout}, 32'h0);
    chk("carry_flags", {28'd0, last_flags}, 32'h9);

    // Multiply: flags forced to zero; sticky keeps the add's bits
    set_req(0, 4'd2, 4'd3, 4'd5); issue(2'b01); wait_idle();
    chk("mul_dout", {28'd0, last_dout}, 32'hF);
    chk("mul_flags", {28'd0, last_flags}, 32'h0);
    chk("sticky_hist", {28'd0, sticky_flags}, {28'd0, exp_sticky_hist});

    // Unsupported opcode
    set_req(0, 4'hA, 4'd6, 4'd9); issue(2'b01); wait_idle();
    chk("unsup_dout", {28'd0, last_dout}, 32'h0);
    chk("unsup_flags", {28'd0, last_flags}, 32'h0);

    // cmp 5-5 with flags_clr asserted only in the capture (EXEC) cycle
    set_req(1, 4'd3, 4'd5, 4'd5); issue(2'b10);
    flags_clr = 1'b1;
    @(posedge clk); #1 flags_clr = 1'b0;
    wait_idle();
    chk("cmp_flags", {28'd0, last_flags}, 32'h8);
    chk("sticky_clr_capture", {28'd0, sticky_flags}, {28'd0, exp_sticky_clr});

    // Response stall with both requesters waiting
    rsp_ready = 1'b0;
    set_req(0, 4'd1, 4'd2, 4'd2); set_req(1, 4'd4, 4'd3, 4'd0);
    issue(2'b01);
    req_valid = 2'b11;
    repeat (6) begin @(posedge clk); #1; end
    chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    g0 = grants_total; ok = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (grants_total != g0) begin ok = 1'b1; break; end
    end
    req_valid = 2'b00;
    chk("stall_regrant", {31'd0, ok}, 32'd1);
    wait_idle();

    // Reset during EXEC drops the operation
    set_req(1, 4'd1, 4'd5, 4'd6); issue(2'b10);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    #2;
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_rsp", {23'd0, rsp_id, rsp_dout, rsp_eflags}, 32'd0);
    chk("midrst_alu_bus", {20'd0, alu_opcode, alu_op1, alu_op2}, 32'd0);
    chk("midrst_sticky", {28'd0, sticky_flags}, 32'd0);
    repeat (6) begin @(posedge clk); #1; end

    // Fairness from the reset pointer: expect 0,1,0,1
    grant_log.delete();
    set_req(0, 4'd1, 4'd1, 4'd1); set_req(1, 4'd3, 4'd9, 4'd2);
    g0 = grants_total;
    req_valid = 2'b11;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (grants_total == g0 + 4) break;
    end
    req_valid = 2'b00;
    wait_idle();
    chk("fair_count", grant_log.size(), 32'd4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      chk("fair_order", {31'd0, grant_log[k]}, k % 2);

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      req_valid  = 2'($urandom);
      req_opcode = 8'($urandom);
      req_op1    = 8'($urandom);
      req_op2    = 8'($urandom);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      flags_clr  = ($urandom_range(0, 7) == 0);
    end
    req_valid = 2'b00; rsp_ready = 1'b1; flags_clr = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

endmodule
`default_nettype wire
